// File: rtl/pixel_compositor.sv
// pixel_compositor: HDMI pixel output stage.
//   Generates raster timing from free-running h/v counters, delays sync/DE to
//   line up with externally fetched layer pixels, and composites NUM_LAYERS
//   overlay layers over a background using fixed priority (highest index wins).
//   Layer enables are captured once per frame so toggles never tear mid-frame.
// Optional feature macro: ALPHA_BLEND_EN
//   When defined, the top layer is alpha-blended over the priority result of the
//   lower layers. This adds the layer_alpha port and one pipeline stage.
// Ports:
//   clk_vga, reset                  pixel clock, synchronous active-high reset
//   layer_rgb/layer_valid/layer_en  per-layer pixel, coverage, requested enable
//   bg_rgb                          background pixel
//   layer_alpha                     top-layer alpha (ALPHA_BLEND_EN only)
//   hdata_o/vdata_o/frame_start_o   raster position for the layer painters
//   video_*_O                       composited RGB, syncs, DE and pixel clock
module pixel_compositor #(
  parameter int   WIDTH      = 12,
  parameter int   HSIZE      = 640,
  parameter int   HFP        = 656,
  parameter int   HSP        = 752,
  parameter int   HMAX       = 800,
  parameter int   VSIZE      = 480,
  parameter int   VFP        = 490,
  parameter int   VSP        = 492,
  parameter int   VMAX       = 525,
  parameter logic HSPP       = 1'b0,
  parameter logic VSPP       = 1'b0,
  parameter int   NUM_LAYERS = 3,
  parameter int   LAYER_LAT  = 1
) (
  input  logic                      clk_vga,
  input  logic                      reset,
  input  logic [24*NUM_LAYERS-1:0]  layer_rgb,
  input  logic [NUM_LAYERS-1:0]     layer_valid,
  input  logic [NUM_LAYERS-1:0]     layer_en,
  input  logic [23:0]               bg_rgb,
`ifdef ALPHA_BLEND_EN
  input  logic [7:0]                layer_alpha,
`endif
  output logic [WIDTH-1:0]          hdata_o,
  output logic [WIDTH-1:0]          vdata_o,
  output logic                      frame_start_o,
  output logic [7:0]                video_red_O,
  output logic [7:0]                video_green_O,
  output logic [7:0]                video_blue_O,
  output logic                      video_hsync_O,
  output logic                      video_vsync_O,
  output logic                      video_de_O,
  output logic                      video_clk_O
);

  localparam logic [WIDTH-1:0] HSIZE_C = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] HFP_C   = WIDTH'(HFP);
  localparam logic [WIDTH-1:0] HSP_C   = WIDTH'(HSP);
  localparam logic [WIDTH-1:0] HLAST_C = WIDTH'(HMAX - 1);
  localparam logic [WIDTH-1:0] VSIZE_C = WIDTH'(VSIZE);
  localparam logic [WIDTH-1:0] VFP_C   = WIDTH'(VFP);
  localparam logic [WIDTH-1:0] VSP_C   = WIDTH'(VSP);
  localparam logic [WIDTH-1:0] VLAST_C = WIDTH'(VMAX - 1);

  // Control word carried down the delay line: {enables, de, hs, vs}
  localparam int CW = NUM_LAYERS + 3;
  localparam logic [CW-1:0] CTL_IDLE = {{NUM_LAYERS{1'b0}}, 1'b0, ~HSPP, ~VSPP};

  // Per-channel (top*a' + under*(256-a')) >> 8 with a' in 0..256, so that
  // alpha 255 reproduces top and alpha 0 reproduces under exactly.
  function automatic logic [23:0] blend(input logic [23:0] top,
                                        input logic [23:0] under,
                                        input logic [7:0]  alpha);
    logic [8:0]  a;
    logic [16:0] acc;
    logic [23:0] res;
    a   = {1'b0, alpha} + {8'd0, alpha[7]};
    res = '0;
    for (int c = 0; c < 3; c++) begin
      acc = 17'(top[8*c +: 8]) * 17'(a) + 17'(under[8*c +: 8]) * (17'd256 - 17'(a));
      res[8*c +: 8] = acc[15:8];
    end
    return res;
  endfunction

  logic [WIDTH-1:0]      h_q, h_d, v_q, v_d;
  logic [NUM_LAYERS-1:0] en_q, en_d, en_p0;
  logic                  frame_start;
  logic                  hs_p0, vs_p0, de_p0;
  logic [CW-1:0]         ctl_p0, ctl_al;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HLAST_C) begin
      h_d = '0;
      v_d = (v_q == VLAST_C) ? '0 : v_q + 1'b1;
    end
  end

  // ---- stage 0: raw timing from the counters ----
  always_comb begin
    frame_start = (h_q == '0) && (v_q == '0);
    hs_p0  = (h_q >= HFP_C && h_q < HSP_C) ? HSPP : ~HSPP;
    vs_p0  = (v_q >= VFP_C && v_q < VSP_C) ? VSPP : ~VSPP;
    de_p0  = (h_q < HSIZE_C) && (v_q < VSIZE_C);
    // The enable set that applies to this pixel travels with it, so a frame
    // start capture never reaches pixels of the previous frame still in flight.
    en_p0  = frame_start ? layer_en : en_q;
    en_d   = en_p0;
    ctl_p0 = {en_p0, de_p0, hs_p0, vs_p0};
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      en_q <= '0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      en_q <= en_d;
    end
  end

  // ---- stage 0 -> aligned: LAYER_LAT-deep delay line ----
  generate
    if (LAYER_LAT == 0) begin : g_nodly
      assign ctl_al = ctl_p0;
    end else begin : g_dly
      logic [CW-1:0] dly_q [LAYER_LAT];
      logic [CW-1:0] dly_d [LAYER_LAT];
      always_comb begin
        dly_d[0] = ctl_p0;
        for (int i = 1; i < LAYER_LAT; i++) dly_d[i] = dly_q[i-1];
      end
      always_ff @(posedge clk_vga) begin
        for (int i = 0; i < LAYER_LAT; i++) dly_q[i] <= reset ? CTL_IDLE : dly_d[i];
      end
      assign ctl_al = dly_q[LAYER_LAT-1];
    end
  endgenerate

  logic [NUM_LAYERS-1:0] en_al;
  logic                  de_al, hs_al, vs_al, top_use;
  logic [23:0]           under, top;

  // ---- aligned stage: priority select against the layer inputs ----
  always_comb begin
    en_al   = ctl_al[CW-1:3];
    de_al   = ctl_al[2];
    hs_al   = ctl_al[1];
    vs_al   = ctl_al[0];
    under   = bg_rgb;
    for (int i = 0; i < NUM_LAYERS - 1; i++)
      if (layer_valid[i] && en_al[i]) under = layer_rgb[24*i +: 24];
    top     = layer_rgb[24*(NUM_LAYERS-1) +: 24];
    top_use = layer_valid[NUM_LAYERS-1] && en_al[NUM_LAYERS-1];
  end

  logic [23:0] pix_q, pix_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;

`ifdef ALPHA_BLEND_EN
  logic [23:0] under_p1_q, under_p1_d, top_p1_q, top_p1_d;
  logic [7:0]  alpha_p1_q, alpha_p1_d;
  logic        use_p1_q, use_p1_d, de_p1_q, de_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;

  always_comb begin
    under_p1_d = under;
    top_p1_d   = top;
    alpha_p1_d = layer_alpha;
    use_p1_d   = top_use;
    de_p1_d    = de_al;
    hs_p1_d    = hs_al;
    vs_p1_d    = vs_al;
  end

  // ---- aligned -> p1: blend operands registered ----
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      under_p1_q <= '0;
      top_p1_q   <= '0;
      alpha_p1_q <= '0;
      use_p1_q   <= 1'b0;
      de_p1_q    <= 1'b0;
      hs_p1_q    <= ~HSPP;
      vs_p1_q    <= ~VSPP;
    end else begin
      under_p1_q <= under_p1_d;
      top_p1_q   <= top_p1_d;
      alpha_p1_q <= alpha_p1_d;
      use_p1_q   <= use_p1_d;
      de_p1_q    <= de_p1_d;
      hs_p1_q    <= hs_p1_d;
      vs_p1_q    <= vs_p1_d;
    end
  end

  always_comb begin
    pix_d = '0;
    if (de_p1_q) pix_d = use_p1_q ? blend(top_p1_q, under_p1_q, alpha_p1_q) : under_p1_q;
    de_d  = de_p1_q;
    hs_d  = hs_p1_q;
    vs_d  = vs_p1_q;
  end
`else
  always_comb begin
    pix_d = '0;
    if (de_al) pix_d = top_use ? top : under;
    de_d  = de_al;
    hs_d  = hs_al;
    vs_d  = vs_al;
  end
`endif

  // ---- output register ----
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      pix_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~HSPP;
      vs_q  <= ~VSPP;
    end else begin
      pix_q <= pix_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign hdata_o       = h_q;
  assign vdata_o       = v_q;
  assign frame_start_o = frame_start;
  assign video_red_O   = pix_q[23:16];
  assign video_green_O = pix_q[15:8];
  assign video_blue_O  = pix_q[7:0];
  assign video_hsync_O = hs_q;
  assign video_vsync_O = vs_q;
  assign video_de_O    = de_q;
  assign video_clk_O   = clk_vga;

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
Next-generation pixel output stage for the HDMI path. It generates 640x480-class raster timing internally and composites NUM_LAYERS parametrised game layers over a background stream using a fixed priority order. Sync and data-enable are delay-matched to a configurable layer-fetch latency. Layer enables are frame-synchronous, so toggling a layer never tears mid-frame. It sits between the layer painters and the mod_top video pins.

Parameters:
WIDTH, 12, coordinate counter width
HSIZE/HFP/HSP/HMAX, 640/656/752/800, horizontal visible end / sync start / sync end / total
VSIZE/VFP/VSP/VMAX, 480/490/492/525, vertical equivalents
HSPP/VSPP, 0/0, sync pulse level (0 = active-low)
NUM_LAYERS, 3, number of overlay layers (1..8); index NUM_LAYERS-1 has highest priority
LAYER_LAT, 1, cycles from hdata_o/vdata_o to matching layer_rgb/bg_rgb (0..4)

Ports:
clk_vga  in  1  pixel clock; also driven out on video_clk_O
reset  in  1  synchronous, active-high
layer_rgb  in  24*NUM_LAYERS  {R,G,B} per layer; layer i at bits [24i+23:24i]
layer_valid  in  NUM_LAYERS  layer i covers the current pixel
layer_en  in  NUM_LAYERS  requested layer enables, sampled at frame start
bg_rgb  in  24  background {R,G,B}
layer_alpha  in  8  top-layer alpha; present only with ALPHA_BLEND_EN
hdata_o  out  WIDTH  current horizontal counter
vdata_o  out  WIDTH  current vertical counter
frame_start_o  out  1  high for the one cycle where hdata_o==0 && vdata_o==0
video_red_O/video_green_O/video_blue_O  out  8 each  composited pixel
video_hsync_O  out  1  horizontal sync
video_vsync_O  out  1  vertical sync
video_de_O  out  1  data enable
video_clk_O  out  1  equals clk_vga

Behaviour:
- Counters: hdata counts 0..HMAX-1 and wraps to 0. vdata increments only on the hdata wrap and itself wraps VMAX-1 -> 0. On reset both go to 0; the first cycle after reset deassertion is (0,0) with frame_start_o=1.
- Raw timing, stage 0:
  - hs = HSPP when HFP <= hdata < HSP, else ~HSPP.
  - vs = VSPP when VFP <= vdata < VSP, else ~VSPP.
  - de = (hdata < HSIZE) && (vdata < VSIZE).
- Enable shadow: en_q is loaded from layer_en only in the frame_start cycle. It resets to 0, so the first frame after reset uses the enables sampled at (0,0).
- Alignment: hs/vs/de are delayed by LAYER_LAT cycles in a shift register, which aligns them with layer inputs. One output register stage follows.
- Latency: video outputs reflect coordinate (h,v) exactly LAYER_LAT+1 cycles after hdata_o/vdata_o showed (h,v).
- Selection: take the highest index i with layer_valid[i] && en_q[i] and use layer_rgb slice i. If no layer qualifies, use bg_rgb.
  - en_q is applied to the pixel at the aligned stage. An en_q change at frame start affects pixels from coordinate (0,0) onward, never the tail of the previous frame.
- Blanking: when the aligned de is 0, RGB outputs are 0 regardless of layer inputs.
- Reset values: RGB 0, de 0, hsync ~HSPP, vsync ~VSPP, delay-line contents cleared to the same idle values, en_q 0.
- Reset mid-frame: counters and pipeline clear on the same edge. No partial pixel or sync pulse is emitted after reset.
- Simultaneous cases: all layers valid gives layer NUM_LAYERS-1. A frame_start coincident with a layer_en change captures the new value.

Optional Feature:
ALPHA_BLEND_EN
- Defined:
  - The layer_alpha port exists, aligned like layer_rgb.
  - Layer NUM_LAYERS-1, when valid and enabled, is blended over the priority result of layers 0..NUM_LAYERS-2 (or bg).
  - Blend: a' = alpha + alpha[7] (range 0..256); per channel out = (top*a' + under*(256-a')) >> 8, computed at 17-bit width.
  - alpha=255 gives exactly top; alpha=0 gives exactly under.
  - One extra pipeline stage is added, so latency becomes LAYER_LAT+2 and syncs are delayed to match.
- Undefined: no layer_alpha port, pure priority select, latency LAYER_LAT+1.

Test Plan:
- Reset, then run one full frame with defaults -> hsync low for hdata 656..751 (96 cycles), 800 cycles per line; vsync low on lines 490..491; 420000 cycles between frame_start_o pulses; de high for 640x480 pixels.
- LAYER_LAT=1, bg=0x102030, no layers valid -> pixel (5,0) outputs 0x102030 exactly 2 cycles after hdata_o=5; pixel (700,10) outputs 0x000000.
- NUM_LAYERS=3, all en, all valid, layer2=0xFF0000, layer1=0x00FF00 -> 0xFF0000. Drop layer2 valid -> 0x00FF00.
- Change layer_en from 3'b111 to 3'b000 at line 100 -> frame continues compositing layers; from the next frame's (0,0) output equals bg.
- Assert reset for 1 cycle at hdata=300, vdata=200 -> next cycle hdata_o=0, vdata_o=0, frame_start_o=1; outputs idle (RGB 0, de 0, syncs high) until the pipeline refills.
- ALPHA_BLEND_EN, top=0xFFFFFF, under bg=0x000000, alpha=0x80 -> 0x808080 at latency LAYER_LAT+2; alpha=0xFF -> 0xFFFFFF; alpha=0x00 -> 0x000000.
